// File: rtl/mc_ctrl.sv
// Multicycle MIPS control FSM: sequences the datapath register enables and mux selects
// one instruction at a time, with a bounded-wait handshake to a shared memory.
module mc_ctrl #(
   parameter int unsigned WAIT_MAX = 255,
   parameter int unsigned CNT_W    = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] opcode,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       mem_we,
   output logic       iord,
   output logic       ir_we,
   output logic       mdr_we,
   output logic       ab_we,
   output logic       aluout_we,
   output logic       pc_we,
   output logic [1:0] pc_src,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] alu_op,
   output logic       reg_we,
   output logic       reg_dst,
   output logic       mem_to_reg,
   output logic       illegal,
   output logic       mem_err
);

   // state     | meaning
   // ----------+-----------------------------------------------
   // S_INIT    | post-reset idle cycle, all outputs low
   // S_FETCH   | read instruction at PC, write IR, PC += 4
   // S_DECODE  | load A/B, precompute branch target into ALUOut
   // S_MEMADR  | ALUOut = A + imm (lw/sw address)
   // S_MEMRD   | read data at ALUOut into MDR
   // S_MEMWB   | rt = MDR
   // S_MEMWR   | write B to memory at ALUOut
   // S_EXEC    | ALUOut = A op B (R-type)
   // S_ALUWB   | rd = ALUOut
   // S_BRANCH  | compare A/B, PC = ALUOut when equal
   // S_ADDIEX  | ALUOut = A + imm (addi)
   // S_ADDIWB  | rt = ALUOut
   // S_JUMP    | PC = jump target
   typedef enum logic [3:0] {
      S_INIT   = 4'd0,
      S_FETCH  = 4'd1,
      S_DECODE = 4'd2,
      S_MEMADR = 4'd3,
      S_MEMRD  = 4'd4,
      S_MEMWB  = 4'd5,
      S_MEMWR  = 4'd6,
      S_EXEC   = 4'd7,
      S_ALUWB  = 4'd8,
      S_BRANCH = 4'd9,
      S_ADDIEX = 4'd10,
      S_ADDIWB = 4'd11,
      S_JUMP   = 4'd12
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_J     = 6'h02;

   localparam logic [CNT_W-1:0] WAIT_LIM = CNT_W'(WAIT_MAX);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             illegal_q, illegal_d;
   logic             mem_err_q, mem_err_d;
   logic             timeout;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_INIT;
         cnt_q     <= '0;
         illegal_q <= 1'b0;
         mem_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         illegal_q <= illegal_d;
         mem_err_q <= mem_err_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      illegal_d  = illegal_q;
      mem_err_d  = mem_err_q;
      timeout    = 1'b0;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      iord       = 1'b0;
      ir_we      = 1'b0;
      mdr_we     = 1'b0;
      ab_we      = 1'b0;
      aluout_we  = 1'b0;
      pc_we      = 1'b0;
      pc_src     = 2'd0;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'd0;
      alu_op     = 2'd0;
      reg_we     = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;

      case (state_q)
         S_INIT: state_d = S_FETCH;
         S_FETCH: begin
            mem_req   = 1'b1;
            alu_src_b = 2'd1;
            if (mem_ready) begin
               ir_we   = 1'b1;
               pc_we   = 1'b1;
               state_d = S_DECODE;
            end else if (cnt_q == WAIT_LIM) begin
               timeout = 1'b1;
            end
         end
         S_DECODE: begin
            alu_src_b = 2'd3;
            ab_we     = 1'b1;
            aluout_we = 1'b1;
            case (opcode)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_RTYPE:     state_d = S_EXEC;
               OP_BEQ:       state_d = S_BRANCH;
               OP_ADDI:      state_d = S_ADDIEX;
               OP_J:         state_d = S_JUMP;
               default: begin
                  state_d   = S_FETCH;
                  illegal_d = 1'b1;
               end
            endcase
         end
         S_MEMADR: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'd2;
            aluout_we = 1'b1;
            state_d   = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
         end
         S_MEMRD: begin
            mem_req = 1'b1;
            iord    = 1'b1;
            if (mem_ready) begin
               mdr_we  = 1'b1;
               state_d = S_MEMWB;
            end else if (cnt_q == WAIT_LIM) begin
               timeout = 1'b1;
            end
         end
         S_MEMWB: begin
            reg_we     = 1'b1;
            mem_to_reg = 1'b1;
            state_d    = S_FETCH;
         end
         S_MEMWR: begin
            mem_req = 1'b1;
            mem_we  = 1'b1;
            iord    = 1'b1;
            if (mem_ready) begin
               state_d = S_FETCH;
            end else if (cnt_q == WAIT_LIM) begin
               timeout = 1'b1;
            end
         end
         S_EXEC: begin
            alu_src_a = 1'b1;
            alu_op    = 2'd2;
            aluout_we = 1'b1;
            state_d   = S_ALUWB;
         end
         S_ALUWB: begin
            reg_we  = 1'b1;
            reg_dst = 1'b1;
            state_d = S_FETCH;
         end
         S_BRANCH: begin
            alu_src_a = 1'b1;
            alu_op    = 2'd1;
            pc_src    = 2'd1;
            pc_we     = zero;
            state_d   = S_FETCH;
         end
         S_ADDIEX: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'd2;
            aluout_we = 1'b1;
            state_d   = S_ADDIWB;
         end
         S_ADDIWB: begin
            reg_we  = 1'b1;
            state_d = S_FETCH;
         end
         S_JUMP: begin
            pc_src  = 2'd2;
            pc_we   = 1'b1;
            state_d = S_FETCH;
         end
         default: state_d = S_INIT;
      endcase

      // A timed-out access fires no enable, so a FETCH retry reuses the same PC.
      if (timeout) begin
         state_d   = S_FETCH;
         mem_err_d = 1'b1;
      end

      if ((state_d != state_q) || timeout) begin
         cnt_d = '0;
      end else if (mem_req && !mem_ready) begin
         cnt_d = cnt_q + 1'b1;
      end else begin
         cnt_d = cnt_q;
      end
   end

   assign illegal = illegal_q;
   assign mem_err = mem_err_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Scoreboard bench for mc_ctrl: per-instruction step lists push expected control words,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_mc_ctrl;

   localparam int WAIT_MAX = 4;

   localparam logic [5:0] OP_R    = 6'h00;
   localparam logic [5:0] OP_LW   = 6'h23;
   localparam logic [5:0] OP_SW   = 6'h2B;
   localparam logic [5:0] OP_BEQ  = 6'h04;
   localparam logic [5:0] OP_ADDI = 6'h08;
   localparam logic [5:0] OP_J    = 6'h02;

   // control word field masks
   localparam logic [17:0] REQ     = 18'd1 << 17;
   localparam logic [17:0] WE      = 18'd1 << 16;
   localparam logic [17:0] IORD    = 18'd1 << 15;
   localparam logic [17:0] IRWE    = 18'd1 << 14;
   localparam logic [17:0] MDRWE   = 18'd1 << 13;
   localparam logic [17:0] ABWE    = 18'd1 << 12;
   localparam logic [17:0] ALUWE   = 18'd1 << 11;
   localparam logic [17:0] PCWE    = 18'd1 << 10;
   localparam logic [17:0] PCS_OUT = 18'd1 << 8;
   localparam logic [17:0] PCS_J   = 18'd2 << 8;
   localparam logic [17:0] ASA     = 18'd1 << 7;
   localparam logic [17:0] ASB_4   = 18'd1 << 5;
   localparam logic [17:0] ASB_IMM = 18'd2 << 5;
   localparam logic [17:0] ASB_SH  = 18'd3 << 5;
   localparam logic [17:0] AOP_SUB = 18'd1 << 3;
   localparam logic [17:0] AOP_F   = 18'd2 << 3;
   localparam logic [17:0] REGWE   = 18'd1 << 2;
   localparam logic [17:0] REGDST  = 18'd1 << 1;
   localparam logic [17:0] M2R     = 18'd1;

   localparam logic [17:0] W_FETCH  = REQ | ASB_4;
   localparam logic [17:0] W_DECODE = ASB_SH | ABWE | ALUWE;
   localparam logic [17:0] W_ADDR   = ASA | ASB_IMM | ALUWE;
   localparam logic [17:0] W_MEMRD  = REQ | IORD;
   localparam logic [17:0] W_MEMWR  = REQ | WE | IORD;
   localparam logic [17:0] W_MEMWB  = REGWE | M2R;
   localparam logic [17:0] W_EXEC   = ASA | AOP_F | ALUWE;
   localparam logic [17:0] W_ALUWB  = REGWE | REGDST;
   localparam logic [17:0] W_ADDIWB = REGWE;
   localparam logic [17:0] W_BRANCH = ASA | AOP_SUB | PCS_OUT;
   localparam logic [17:0] W_JUMP   = PCS_J | PCWE;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [5:0] opcode;
   logic       zero;
   logic       mem_ready;
   logic       mem_req, mem_we, iord, ir_we, mdr_we, ab_we, aluout_we, pc_we;
   logic [1:0] pc_src, alu_src_b, alu_op;
   logic       alu_src_a, reg_we, reg_dst, mem_to_reg, illegal, mem_err;

   mc_ctrl #(.WAIT_MAX(WAIT_MAX), .CNT_W(3)) dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
      .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_we(ir_we), .mdr_we(mdr_we),
      .ab_we(ab_we), .aluout_we(aluout_we), .pc_we(pc_we), .pc_src(pc_src),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .reg_we(reg_we),
      .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .illegal(illegal), .mem_err(mem_err)
   );

   always #5 clk = ~clk;

   logic [19:0] exp_q[$];
   string       name_q[$];
   logic        ill_m = 1'b0;
   logic        err_m = 1'b0;
   int          n_tests = 0;
   int          n_fail  = 0;

   function automatic logic rb();
      return 1'($urandom);
   endfunction

   // One clock cycle: drive inputs just after the edge and queue the expected outputs.
   task automatic step(input logic rst, input logic [5:0] op, input logic z,
                       input logic rdy, input logic [17:0] ctl, input string nm);
      @(posedge clk);
      #1;
      rst_n     = rst;
      opcode    = op;
      zero      = z;
      mem_ready = rdy;
      if (!rst) begin
         ill_m = 1'b0;
         err_m = 1'b0;
      end
      exp_q.push_back({ctl, ill_m, err_m});
      name_q.push_back(nm);
   endtask

   task automatic do_reset();
      step(1'b0, 6'h00, rb(), rb(), 18'd0, "reset");
      step(1'b1, 6'h00, rb(), 1'b1, 18'd0, "init");
   endtask

   // kind: 0 fetch, 1 read, 2 write; ready arrives on request cycle dly (0-based)
   task automatic mem_access(input int kind, input logic [5:0] op, input int dly,
                             output logic done);
      logic [17:0] base, fin;
      string       nm;
      case (kind)
         0: begin base = W_FETCH; fin = W_FETCH | IRWE | PCWE; nm = "fetch"; end
         1: begin base = W_MEMRD; fin = W_MEMRD | MDRWE;       nm = "memrd"; end
         default: begin base = W_MEMWR; fin = W_MEMWR;         nm = "memwr"; end
      endcase
      done = 1'b0;
      for (int i = 0; i <= WAIT_MAX; i++) begin
         if (i == dly) begin
            step(1'b1, op, rb(), 1'b1, fin, nm);
            done = 1'b1;
            break;
         end
         step(1'b1, op, rb(), 1'b0, base, nm);
      end
      if (!done) err_m = 1'b1;
   endtask

   task automatic run_instr(input logic [5:0] op, input logic z, input int df, input int dm);
      logic ok;
      mem_access(0, op, df, ok);
      if (!ok) return;
      step(1'b1, op, rb(), rb(), W_DECODE, "decode");
      case (op)
         OP_LW, OP_SW: begin
            step(1'b1, op, rb(), rb(), W_ADDR, "memadr");
            mem_access((op == OP_LW) ? 1 : 2, op, dm, ok);
            if (ok && op == OP_LW) step(1'b1, op, rb(), rb(), W_MEMWB, "memwb");
         end
         OP_R: begin
            step(1'b1, op, rb(), rb(), W_EXEC, "exec");
            step(1'b1, op, rb(), rb(), W_ALUWB, "aluwb");
         end
         OP_BEQ:  step(1'b1, op, z, rb(), W_BRANCH | (z ? PCWE : 18'd0), "branch");
         OP_ADDI: begin
            step(1'b1, op, rb(), rb(), W_ADDR, "addiex");
            step(1'b1, op, rb(), rb(), W_ADDIWB, "addiwb");
         end
         OP_J:    step(1'b1, op, rb(), rb(), W_JUMP, "jump");
         default: ill_m = 1'b1;
      endcase
   endtask

   function automatic int rnd_dly();
      if ($urandom_range(0, 9) == 0) return int'($urandom_range(3, 6));
      return int'($urandom_range(0, 2));
   endfunction

   initial begin : monitor
      logic [19:0] e, act;
      string       nm;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            nm  = name_q.pop_front();
            act = {mem_req, mem_we, iord, ir_we, mdr_we, ab_we, aluout_we, pc_we, pc_src,
                   alu_src_a, alu_src_b, alu_op, reg_we, reg_dst, mem_to_reg, illegal, mem_err};
            n_tests++;
            if (act !== e) begin
               n_fail++;
               $display("FAIL %s @%0t: outputs got %05h expected %05h", nm, $time, act, e);
            end
         end
      end
   end

   initial begin : stimulus
      logic [5:0] ops[6];
      logic [5:0] bad[4];
      logic       ok;
      ops = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J};
      bad = '{6'h3F, 6'h01, 6'h0F, 6'h2C};
      rst_n = 1'b0; opcode = 6'h00; zero = 1'b0; mem_ready = 1'b0;

      step(1'b0, 6'h00, 1'b0, 1'b1, 18'd0, "reset");
      step(1'b0, 6'h00, 1'b0, 1'b1, 18'd0, "reset");
      step(1'b1, 6'h00, 1'b0, 1'b1, 18'd0, "init");
      run_instr(OP_R, 1'b0, 0, 0);
      run_instr(OP_LW, 1'b0, 0, 3);
      run_instr(OP_BEQ, 1'b1, 0, 0);
      run_instr(OP_BEQ, 1'b0, 1, 0);
      run_instr(6'h3F, 1'b0, 0, 0);
      run_instr(OP_J, 1'b0, 0, 0);
      run_instr(OP_ADDI, 1'b0, 2, 0);
      run_instr(OP_SW, 1'b0, 0, 99);
      run_instr(OP_SW, 1'b0, 0, 3);
      run_instr(OP_SW, 1'b0, 0, WAIT_MAX);
      run_instr(OP_R, 1'b0, 99, 0);
      run_instr(OP_LW, 1'b0, WAIT_MAX, 99);

      // reset in the middle of a stalled fetch: outputs and flags drop at once
      step(1'b1, OP_R, 1'b0, 1'b0, W_FETCH, "fetch");
      step(1'b1, OP_R, 1'b0, 1'b0, W_FETCH, "fetch");
      step(1'b0, OP_R, 1'b0, 1'b1, 18'd0, "reset_mid");
      step(1'b1, OP_R, 1'b0, 1'b1, 18'd0, "init");

      for (int n = 0; n < 300; n++) begin
         logic [5:0] op;
         if ($urandom_range(0, 9) == 0) op = bad[$urandom_range(0, 3)];
         else                           op = ops[$urandom_range(0, 5)];
         run_instr(op, rb(), rnd_dly(), rnd_dly());
         if ($urandom_range(0, 59) == 0) do_reset();
      end

      repeat (3) @(posedge clk);
      n_tests++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d expected words left, required 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
